// File: rtl/muldiv_unit_pkg.sv
// ---------------------------------------------------------------------------
// lcpu_muldiv_pkg
// Shared definitions for the LCPU iterative multiply/divide unit:
//   - MULDIV_WIDTH : default operand / HI / LO width
//   - op_t         : operation encodings carried on the op bus
//   - state_t      : FSM state encodings (also exported on the debug port)
// ---------------------------------------------------------------------------
package lcpu_muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } state_t;

endpackage

// File: rtl/muldiv_unit_if.sv
// ---------------------------------------------------------------------------
// muldiv_unit_if
// Bus between the execute stage (master) and the multiply/divide unit (slave).
//
// Handshake: the master raises start for one cycle with op/a/b valid; the
// unit accepts it on the next rising edge only if busy==0 at that edge
// (a start seen while busy==1 is dropped, operands not captured). After
// acceptance busy stays high until the result cycle, in which busy==0 and
// done==1 for exactly one cycle; hi/lo hold the result from that cycle on.
// mthi/mtlo are single-cycle write strobes honoured only when busy==0 and
// start==0; start takes priority over a coincident mthi/mtlo.
//
// Signals: start, op[1:0], a, b, mthi, mtlo, wdata   (master -> slave)
//          busy, done, hi, lo                         (slave -> master)
// ---------------------------------------------------------------------------
interface muldiv_unit_if
  import lcpu_muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, mthi, mtlo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit_step.sv
// ---------------------------------------------------------------------------
// muldiv_step
// Combinational single iteration on the {acc, q} register pair.
//   i_is_div = 0 : shift-add multiply step. q holds the remaining multiplier
//                  bits; product bits shift in from the top, so after WIDTH
//                  steps {acc[WIDTH-1:0], q} is the full product.
//   i_is_div = 1 : restoring divide step. {acc, q} shifts left one bit, the
//                  divisor is trial-subtracted from acc and the quotient bit
//                  enters q[0]. After WIDTH steps q = quotient, acc = remainder.
// Ports:
//   i_is_div  select multiply / divide step
//   i_acc     partial product / partial remainder (WIDTH+1 bits)
//   i_q       multiplier / dividend-quotient shift register
//   i_m       multiplicand / divisor magnitude
//   o_acc     next acc
//   o_q       next q
// ---------------------------------------------------------------------------
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             i_is_div,
  input  logic [WIDTH:0]   i_acc,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_m,
  output logic [WIDTH:0]   o_acc,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_sh;
  logic [WIDTH+1:0] w_trial;

  always_comb begin
    w_sum   = i_acc + (i_q[0] ? {1'b0, i_m} : {(WIDTH+1){1'b0}});
    w_sh    = {i_acc[WIDTH-1:0], i_q[WIDTH-1]};
    // One extra bit so the borrow of the trial subtraction is visible.
    w_trial = {1'b0, w_sh} - {2'b00, i_m};
    o_acc   = {1'b0, w_sum[WIDTH:1]};
    o_q     = {w_sum[0], i_q[WIDTH-1:1]};
    if (i_is_div) begin
      if (!w_trial[WIDTH+1]) begin
        o_acc = w_trial[WIDTH:0];
        o_q   = {i_q[WIDTH-2:0], 1'b1};
      end else begin
        o_acc = w_sh;
        o_q   = {i_q[WIDTH-2:0], 1'b0};
      end
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// Iterative multiply/divide unit with HI/LO registers for the LCPU execute
// stage. Signed ops are handled on magnitudes; the result signs are latched
// at start and applied in the FIX state.
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset (aborts any op in flight)
//   bus          muldiv_unit_if.slave: start/op/a/b/mthi/mtlo/wdata in,
//                busy/done/hi/lo out
//   o_dbg_state  current FSM state (debug)
// Configuration macro: MULDIV_FAST_MUL_EN
//   defined   : MULT/MULTU go IDLE -> FIX and use one array multiply
//               (done one edge after start); DIV/DIVU unchanged.
//   undefined : every op iterates WIDTH steps (WIDTH+1 edges to done).
// ---------------------------------------------------------------------------
module muldiv_unit
  import lcpu_muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  muldiv_unit_if.slave        bus,
  output state_t              o_dbg_state
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;
  logic             r_is_div;
  logic             r_neg_q;   // sign of product / quotient
  logic             r_neg_r;   // sign of remainder (= sign of dividend)
  logic             r_dz;      // divide by zero
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  op_t              w_op;
  logic             w_signed;
  logic             w_is_div;
  logic             w_sa;
  logic             w_sb;
  logic [WIDTH-1:0] w_ma;
  logic [WIDTH-1:0] w_mb;
  logic [WIDTH:0]   w_step_acc;
  logic [WIDTH-1:0] w_step_q;
  logic [2*WIDTH-1:0] w_prod_mag;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_hi_fix;
  logic [WIDTH-1:0] w_lo_fix;

  // Operand decode and magnitudes, valid in the start cycle.
  always_comb begin
    w_op     = op_t'(bus.op);
    w_signed = (w_op == OP_MULT) || (w_op == OP_DIV);
    w_is_div = (w_op == OP_DIV) || (w_op == OP_DIVU);
    w_sa     = w_signed & bus.a[WIDTH-1];
    w_sb     = w_signed & bus.b[WIDTH-1];
    w_ma     = w_sa ? -bus.a : bus.a;
    w_mb     = w_sb ? -bus.b : bus.b;
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_is_div (r_is_div),
    .i_acc    (r_acc),
    .i_q      (r_q),
    .i_m      (r_m),
    .o_acc    (w_step_acc),
    .o_q      (w_step_q)
  );

  // Sign correction applied in FIX. A magnitude of 2^(WIDTH-1) negates to
  // itself, which gives the wrapped result for the most-negative / -1 case.
  always_comb begin
`ifdef MULDIV_FAST_MUL_EN
    // Multiplies never pass through RUN here, so in FIX a multiply always
    // takes the array product of the latched magnitudes.
    if (r_is_div)
      w_prod_mag = {r_acc[WIDTH-1:0], r_q};
    else
      w_prod_mag = {{WIDTH{1'b0}}, r_m} * {{WIDTH{1'b0}}, r_q};
`else
    w_prod_mag = {r_acc[WIDTH-1:0], r_q};
`endif
    w_prod = r_neg_q ? -w_prod_mag : w_prod_mag;
    if (r_is_div) begin
      // Divide by zero: the restoring loop leaves |a| in acc, and the
      // remainder sign fix restores a itself; only LO needs forcing.
      w_hi_fix = r_neg_r ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
      w_lo_fix = r_dz ? {WIDTH{1'b1}} : (r_neg_q ? -r_q : r_q);
    end else begin
      w_hi_fix = w_prod[2*WIDTH-1:WIDTH];
      w_lo_fix = w_prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_m      <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_is_div <= w_is_div;
            r_neg_q  <= w_sa ^ w_sb;
            r_neg_r  <= w_sa;
            r_dz     <= w_is_div && (bus.b == '0);
            r_acc    <= '0;
            // Multiply: q = multiplier, m = multiplicand.
            // Divide:   q = dividend,   m = divisor.
            r_q      <= w_is_div ? w_ma : w_mb;
            r_m      <= w_is_div ? w_mb : w_ma;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
`ifdef MULDIV_FAST_MUL_EN
            if (!w_is_div) r_state <= S_FIX;
`endif
          end else begin
            if (bus.mthi) r_hi <= bus.wdata;
            if (bus.mtlo) r_lo <= bus.wdata;
          end
        end
        S_RUN: begin
          r_acc <= w_step_acc;
          r_q   <= w_step_q;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) r_state <= S_FIX;
        end
        S_FIX: begin
          r_hi    <= w_hi_fix;
          r_lo    <= w_lo_fix;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.hi      = r_hi;
  assign bus.lo      = r_lo;
  assign o_dbg_state = r_state;
endmodule
